// File: rtl/sample_frame_loader.sv
`timescale 1ns/1ps
// sample_frame_loader
// Serial-to-parallel front end for the 16-input signed summation datapath.
// Signed samples arrive one per cycle over a valid/ready handshake. They are
// collected in a fill buffer, and each completed frame moves into a held
// output register. Lane k of frame_out drives adder-tree input k (a..p).
// The fill buffer and the output register form a double buffer: the next
// frame can fill while the current one waits for frame_ack.
module sample_frame_loader #(
    parameter int DATAWIDTH   = 8,
    parameter int NUM_SAMPLES = 16
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic signed [DATAWIDTH-1:0]        in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NUM_SAMPLES*DATAWIDTH-1:0]   frame_out,
    output logic                               frame_valid,
    input  logic                               frame_ack,
    output logic [7:0]                         frame_id
);

    localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [DATAWIDTH-1:0]             fill_buf [NUM_SAMPLES];
    logic [NUM_SAMPLES*DATAWIDTH-1:0] fill_flat;
    logic [IDX_W-1:0]                 wr_idx;
    logic                             fill_full;
    logic                             accept;
    logic                             transfer;

    // A full fill buffer blocks intake until its frame moves out, which
    // leaves one bubble cycle per frame. Reset also holds in_ready low.
    assign in_ready = Rst & ~fill_full;
    assign accept   = in_valid & in_ready;
    // The output slot is free when it is empty or is being acked this cycle.
    assign transfer = fill_full & (~frame_valid | frame_ack);

    // Pack the fill lanes so that lane k sits at bits [DW*k +: DW].
    always_comb begin
        fill_flat = '0;
        for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
            fill_flat[i*DATAWIDTH +: DATAWIDTH] = fill_buf[i];
        end
    end

    // Sample intake, frame transfer, and acknowledge handling.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
                fill_buf[i] <= '0;
            end
            wr_idx      <= '0;
            fill_full   <= 1'b0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            frame_id    <= '0;
        end else begin
            // accept and transfer never happen together, because fill_full
            // forces in_ready low. Their fill_full updates therefore cannot
            // conflict.
            if (accept) begin
                fill_buf[wr_idx] <= in_data;
                if (wr_idx == LAST_IDX) begin
                    wr_idx    <= '0;
                    fill_full <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + IDX_ONE;
                end
            end

            if (transfer) begin
                frame_out   <= fill_flat;
                frame_valid <= 1'b1;
                fill_full   <= 1'b0;
                frame_id    <= frame_id + 8'd1;
            end else if (frame_ack && frame_valid) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_loader.sv
`timescale 1ns/1ps
// Directed testbench for sample_frame_loader. It uses hand-computed expected frames.
module tb_sample_frame_loader;

    localparam int DW = 8;
    localparam int NS = 16;

    logic               Clk = 1'b0;
    logic               Rst;
    logic [DW-1:0]      in_data;
    logic               in_valid;
    logic               in_ready;
    logic [NS*DW-1:0]   frame_out;
    logic               frame_valid;
    logic               frame_ack;
    logic [7:0]         frame_id;

    int total = 0;
    int bad   = 0;

    logic [NS*DW-1:0] exp_frame;
    logic [NS*DW-1:0] f1;
    logic [NS*DW-1:0] f2;
    logic             flag;

    always #5 Clk = ~Clk;

    sample_frame_loader #(
        .DATAWIDTH  (DW),
        .NUM_SAMPLES(NS)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frame_out  (frame_out),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .frame_id   (frame_id)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0; in_valid = 1'b0; in_data = '0; frame_ack = 1'b0;
        step(); step();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", frame_valid); end
        total++; if (frame_id !== 8'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", frame_id); end
        total++; if (frame_out !== '0) begin bad++; $display("FAIL reset_frame got=%h want=0", frame_out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%0b want=0", in_ready); end
        Rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_high got=%0b want=1", in_ready); end
    endtask

    task automatic test_stream();
        frame_ack = 1'b1;
        flag = 1'b1;
        for (int k = 0; k < NS; k++) begin
            if (in_ready !== 1'b1) flag = 1'b0;
            push(DW'(k + 1));
            exp_frame[k*DW +: DW] = DW'(k + 1);
        end
        total++; if (flag !== 1'b1) begin bad++; $display("FAIL stream_ready_during_fill got=%0b want=1", flag); end
        // Bubble: in_valid stays high, but this sample must not be taken.
        in_data = 8'h55; in_valid = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stream_bubble_ready got=%0b want=0", in_ready); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL stream_valid_early got=%0b want=0", frame_valid); end
        step();
        in_valid = 1'b0;
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%0b want=1", frame_valid); end
        total++; if (frame_id !== 8'd1) begin bad++; $display("FAIL stream_id got=%0d want=1", frame_id); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_after got=%0b want=1", in_ready); end
        total++; if (frame_out !== exp_frame) begin bad++; $display("FAIL stream_frame got=%h want=%h", frame_out, exp_frame); end
    endtask

    task automatic test_sign();
        logic [DW-1:0] pat [4];
        pat[0] = 8'h80; pat[1] = 8'h7F; pat[2] = 8'hFF; pat[3] = 8'h00;
        frame_ack = 1'b1;
        for (int k = 0; k < NS; k++) begin
            push(pat[k % 4]);
            exp_frame[k*DW +: DW] = pat[k % 4];
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sign_bubble_ready got=%0b want=0", in_ready); end
        step();
        total++; if (frame_out !== exp_frame) begin bad++; $display("FAIL sign_frame got=%h want=%h", frame_out, exp_frame); end
        total++; if (frame_id !== 8'd2) begin bad++; $display("FAIL sign_id got=%0d want=2", frame_id); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL sign_valid got=%0b want=1", frame_valid); end
    endtask

    task automatic test_backpressure();
        Rst = 1'b0; frame_ack = 1'b0; in_valid = 1'b0;
        step();
        Rst = 1'b1;
        for (int k = 0; k < NS; k++) begin
            push(DW'(8'h20 + k));
            f1[k*DW +: DW] = DW'(8'h20 + k);
        end
        step();
        total++; if (frame_id !== 8'd1 || frame_valid !== 1'b1) begin bad++; $display("FAIL bp_first id=%0d valid=%0b want id=1 valid=1", frame_id, frame_valid); end
        total++; if (frame_out !== f1) begin bad++; $display("FAIL bp_first_frame got=%h want=%h", frame_out, f1); end
        for (int k = 0; k < NS; k++) begin
            push(DW'(8'h40 + k));
            f2[k*DW +: DW] = DW'(8'h40 + k);
        end
        // The second frame is full and the first frame is unacknowledged.
        // Extra samples offered here must be refused.
        in_data = 8'h77; in_valid = 1'b1;
        flag = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (in_ready !== 1'b0 || frame_out !== f1 || frame_id !== 8'd1 || frame_valid !== 1'b1) flag = 1'b0;
            step();
        end
        total++; if (flag !== 1'b1) begin bad++; $display("FAIL bp_hold_stable got=%0b want=1", flag); end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0; in_valid = 1'b0;
        total++; if (frame_out !== f2) begin bad++; $display("FAIL bp_second_frame got=%h want=%h", frame_out, f2); end
        total++; if (frame_id !== 8'd2) begin bad++; $display("FAIL bp_second_id got=%0d want=2", frame_id); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_continuous got=%0b want=1", frame_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_resume got=%0b want=1", in_ready); end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL bp_ack_clear got=%0b want=0", frame_valid); end
        total++; if (frame_out !== f2) begin bad++; $display("FAIL bp_frame_kept got=%h want=%h", frame_out, f2); end
    endtask

    task automatic test_gapped();
        frame_ack = 1'b0;
        for (int c = 0; c < 2*NS; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = (c % 2 == 0) ? DW'(10 + c/2) : 8'd99;
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < NS; k++) exp_frame[k*DW +: DW] = DW'(10 + k);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%0b want=1", frame_valid); end
        total++; if (frame_id !== 8'd3) begin bad++; $display("FAIL gap_id got=%0d want=3", frame_id); end
        total++; if (frame_out !== exp_frame) begin bad++; $display("FAIL gap_frame got=%h want=%h", frame_out, exp_frame); end
    endtask

    task automatic test_reset_mid();
        // A frame is still held, and 9 samples are partially filled.
        for (int k = 0; k < 9; k++) push(DW'(8'h30 + k));
        Rst = 1'b0;
        step();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", frame_valid); end
        total++; if (frame_id !== 8'd0) begin bad++; $display("FAIL rmid_id got=%0d want=0", frame_id); end
        total++; if (frame_out !== '0) begin bad++; $display("FAIL rmid_frame got=%h want=0", frame_out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%0b want=0", in_ready); end
        Rst = 1'b1;
        for (int k = 0; k < NS; k++) begin
            push(DW'(100 + k));
            exp_frame[k*DW +: DW] = DW'(100 + k);
        end
        step();
        total++; if (frame_out[DW-1:0] !== 8'd100) begin bad++; $display("FAIL rmid_lane0 got=%0d want=100", frame_out[DW-1:0]); end
        total++; if (frame_out !== exp_frame) begin bad++; $display("FAIL rmid_full got=%h want=%h", frame_out, exp_frame); end
        total++; if (frame_id !== 8'd1) begin bad++; $display("FAIL rmid_new_id got=%0d want=1", frame_id); end
    endtask

    task automatic test_wrap();
        frame_ack = 1'b1;
        for (int f = 2; f <= 255; f++) begin
            for (int k = 0; k < NS; k++) push(DW'(f + k));
            step();
        end
        for (int k = 0; k < NS; k++) exp_frame[k*DW +: DW] = DW'(255 + k);
        total++; if (frame_id !== 8'd255) begin bad++; $display("FAIL wrap_id255 got=%0d want=255", frame_id); end
        total++; if (frame_out !== exp_frame) begin bad++; $display("FAIL wrap_frame255 got=%h want=%h", frame_out, exp_frame); end
        step();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL wrap_ack_clear got=%0b want=0", frame_valid); end
        // Spurious ack while frame_valid is low.
        step(); step(); step();
        total++; if (frame_valid !== 1'b0 || frame_id !== 8'd255) begin bad++; $display("FAIL spurious_ack valid=%0b id=%0d want valid=0 id=255", frame_valid, frame_id); end
        total++; if (frame_out !== exp_frame) begin bad++; $display("FAIL spurious_frame got=%h want=%h", frame_out, exp_frame); end
        for (int k = 0; k < NS; k++) begin
            push(DW'(k * 3));
            exp_frame[k*DW +: DW] = DW'(k * 3);
        end
        step();
        total++; if (frame_id !== 8'd0) begin bad++; $display("FAIL wrap_id0 got=%0d want=0", frame_id); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%0b want=1", frame_valid); end
        total++; if (frame_out !== exp_frame) begin bad++; $display("FAIL wrap_frame0 got=%h want=%h", frame_out, exp_frame); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_sign();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
